// File: rtl/tx1_arb_pkg.sv
// Shared types and the rotating first-one search used by the TX1 write arbiter.
// Header type-field macros normally come from the global ASE header; fallbacks apply only when it is absent.
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif
`ifndef ASE_TX1_WRFENCE
`define ASE_TX1_WRFENCE 4'h5
`endif

package tx1_arb_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef logic [MAX_REQ-1:0]   req_vec_t;
    typedef logic [MAX_IDX_W-1:0] req_idx_t;

    typedef enum logic [1:0] {
        ARB          = 2'd0,
        FENCE_SETTLE = 2'd1,
        FENCE_DRAIN  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(input req_vec_t req, input req_idx_t ptr, input int unsigned n);
        rr_pick_t res;
        req_idx_t j;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            j = req_idx_t'((32'(ptr) + i) % n);
            if (!res.found && (i < n) && req[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tx1_arb_if.sv
// Requester and channel-side signals of the TX1 write arbiter, bundled for port grouping.
interface tx1_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int HDR_WIDTH  = 61,
    parameter int DATA_WIDTH = 512
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][HDR_WIDTH-1:0]  req_meta;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [HDR_WIDTH-1:0]               chan_meta;
    logic [DATA_WIDTH-1:0]              chan_data;
    logic                               chan_write_en;
    logic                               chan_full;
    logic                               chan_empty;

    modport master (
        input  req_valid, req_meta, req_data, chan_full, chan_empty,
        output req_ready, chan_meta, chan_data, chan_write_en
    );

    modport slave (
        output req_valid, req_meta, req_data, chan_full, chan_empty,
        input  req_ready, chan_meta, chan_data, chan_write_en
    );
endinterface

// File: rtl/tx1_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: request vector and pointer in, one-hot grant and index out.
module rr_priority_picker
    import tx1_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(req_vec_t'(req), req_idx_t'(ptr), NUM_REQ);
        found = pick.found;
        idx   = IDX_W'(pick.idx);
        gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = pick.found && (pick.idx == req_idx_t'(i));
        end
    end

endmodule

// File: rtl/tx1_write_arbiter.sv
// Round-robin arbiter serialising NUM_REQ write requesters onto one registered TX1 channel,
// with write fences acting as global ordering points that wait for the channel to drain.
module tx1_write_arbiter
    import tx1_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int HDR_WIDTH     = 61,
    parameter  int DATA_WIDTH    = 512,
    parameter  int SETTLE_CYCLES = 3,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tx1_arb_if.master               bus,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    fence_active,
    output logic [NUM_REQ-1:0][31:0] issue_count
);

    arb_state_e                     state_q, state_d;
    logic [3:0]                     settle_q, settle_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]               grant_id_q, grant_id_d;
    logic [HDR_WIDTH-1:0]           chan_meta_q, chan_meta_d;
    logic [DATA_WIDTH-1:0]          chan_data_q, chan_data_d;
    logic                           chan_we_q, chan_we_d;
    logic                           fence_active_q, fence_active_d;
    logic [NUM_REQ-1:0][31:0]       issue_count_q, issue_count_d;

    logic [NUM_REQ-1:0]             pick_gnt;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_found;
    logic                           can_grant;
    logic                           xfer;
    logic                           xfer_fence;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Ready is gated by reset so the grant is silent while rst_n is held low.
    assign can_grant  = rst_n && (state_q == ARB) && !bus.chan_full;
    assign xfer       = can_grant && pick_found;
    assign xfer_fence = xfer && (bus.req_meta[pick_idx][`TX_META_TYPERANGE] == `ASE_TX1_WRFENCE);

    assign bus.req_ready     = can_grant ? pick_gnt : '0;
    assign bus.chan_meta     = chan_meta_q;
    assign bus.chan_data     = chan_data_q;
    assign bus.chan_write_en = chan_we_q;
    assign grant_id          = grant_id_q;
    assign fence_active      = fence_active_q;
    assign issue_count       = issue_count_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ARB: begin
                if (xfer_fence) begin
                    state_d  = FENCE_SETTLE;
                    settle_d = 4'(SETTLE_CYCLES);
                end
            end
            FENCE_SETTLE: begin
                settle_d = (settle_q == 4'd0) ? 4'd0 : settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = FENCE_DRAIN;
                end
            end
            FENCE_DRAIN: begin
                if (bus.chan_empty) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        chan_we_d      = xfer;
        chan_meta_d    = chan_meta_q;
        chan_data_d    = chan_data_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        issue_count_d  = issue_count_q;
        fence_active_d = (state_d != ARB);
        if (xfer) begin
            chan_meta_d             = bus.req_meta[pick_idx];
            chan_data_d             = bus.req_data[pick_idx];
            rr_ptr_d                = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            grant_id_d              = pick_idx;
            issue_count_d[pick_idx] = issue_count_q[pick_idx] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB;
            settle_q       <= '0;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            chan_meta_q    <= '0;
            chan_data_q    <= '0;
            chan_we_q      <= 1'b0;
            fence_active_q <= 1'b0;
            issue_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            chan_meta_q    <= chan_meta_d;
            chan_data_q    <= chan_data_d;
            chan_we_q      <= chan_we_d;
            fence_active_q <= fence_active_d;
            issue_count_q  <= issue_count_d;
        end
    end

endmodule

// File: tb/tb_tx1_write_arbiter.sv
// Randomised and directed bench for tx1_write_arbiter against a cycle-level behavioural model.
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif
`ifndef ASE_TX1_WRFENCE
`define ASE_TX1_WRFENCE 4'h5
`endif

module tb_tx1_write_arbiter;

    localparam int NR = 4;
    localparam int HW = 61;
    localparam int DW = 512;
    localparam int SC = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           grant_id;
    logic                 fence_active;
    logic [NR-1:0][31:0]  issue_count;

    tx1_arb_if #(.NUM_REQ(NR), .HDR_WIDTH(HW), .DATA_WIDTH(DW)) bus ();

    tx1_write_arbiter #(
        .NUM_REQ(NR), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .grant_id     (grant_id),
        .fence_active (fence_active),
        .issue_count  (issue_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: pointer, fence blocking window, expected channel outputs.
    int            m_ptr;
    bit            m_blocked;
    int            m_fence_edge;
    int            edge_no;
    int            m_cnt [NR];
    int            seq   [NR];
    logic          exp_we;
    logic [HW-1:0] exp_meta;
    logic [DW-1:0] exp_data;
    int            exp_gid;
    int            we_seen;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_blocked = 0;
        exp_we    = 1'b0;
        exp_meta  = '0;
        exp_data  = '0;
        exp_gid   = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic full, input logic empty, input logic [NR-1:0] fen);
        bus.req_valid  = v;
        bus.chan_full  = full;
        bus.chan_empty = empty;
        for (int i = 0; i < NR; i++) begin
            logic [HW-1:0] m;
            m = HW'({$urandom, $urandom});
            m[`TX_META_TYPERANGE] = fen[i] ? `ASE_TX1_WRFENCE : 4'h2;
            bus.req_meta[i] = m;
            bus.req_data[i] = {16{4'(i), 28'(seq[i])}};
        end
    endtask

    // One clock: check ready before the edge, advance the model, check registered outputs after.
    task automatic step(input string tag);
        int            g;
        logic [NR-1:0] er;
        #1;
        g = -1;
        if (!m_blocked && !bus.chan_full) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (g < 0 && bus.req_valid[j]) g = j;
            end
        end
        er = (g >= 0) ? NR'(1 << g) : '0;
        check_val({tag, ".req_ready"}, DW'(bus.req_ready), DW'(er));
        @(posedge clk);
        edge_no++;
        if (m_blocked) begin
            exp_we = 1'b0;
            if (edge_no >= m_fence_edge + SC + 1 && bus.chan_empty) m_blocked = 0;
        end else if (g >= 0) begin
            exp_we   = 1'b1;
            exp_meta = bus.req_meta[g];
            exp_data = bus.req_data[g];
            exp_gid  = g;
            m_ptr    = (g + 1) % NR;
            m_cnt[g]++;
            seq[g]++;
            if (bus.req_meta[g][`TX_META_TYPERANGE] == `ASE_TX1_WRFENCE) begin
                m_blocked    = 1;
                m_fence_edge = edge_no;
            end
        end else begin
            exp_we = 1'b0;
        end
        #1;
        if (bus.chan_write_en === 1'b1) we_seen++;
        check_val({tag, ".we"},    DW'(bus.chan_write_en), DW'(exp_we));
        check_val({tag, ".meta"},  DW'(bus.chan_meta),     DW'(exp_meta));
        check_val({tag, ".data"},  bus.chan_data,          exp_data);
        check_val({tag, ".gid"},   DW'(grant_id),          DW'(exp_gid));
        check_val({tag, ".fence"}, DW'(fence_active),      DW'(m_blocked));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".req_ready"}, DW'(bus.req_ready),     '0);
        check_val({tag, ".we"},        DW'(bus.chan_write_en), '0);
        check_val({tag, ".meta"},      DW'(bus.chan_meta),     '0);
        check_val({tag, ".data"},      bus.chan_data,          '0);
        check_val({tag, ".gid"},       DW'(grant_id),          '0);
        check_val({tag, ".fence"},     DW'(fence_active),      '0);
        for (int i = 0; i < NR; i++) check_val({tag, ".count"}, DW'(issue_count[i]), '0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order [4];
        exp_order = '{3, 1, 3, 1};
        for (int i = 0; i < NR; i++) seq[i] = 0;
        edge_no = 0;
        model_reset();

        // Reset state, with every requester asking.
        drive('1, 1'b0, 1'b1, '0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, 8 back-to-back writes.
        we_seen = 0;
        for (int c = 0; c < 8; c++) begin
            drive(4'b0001, 1'b0, 1'b1, '0);
            step("single");
            @(negedge clk);
        end
        check_val("single.we_run", DW'(we_seen), DW'(8));
        drive('0, 1'b0, 1'b1, '0);
        step("single_idle");
        check_val("single.count0", DW'(issue_count[0]), DW'(8));

        // Fairness: everyone valid for 400 cycles.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drive('1, 1'b0, 1'b1, '0);
            step("fair");
        end
        @(negedge clk);
        drive('0, 1'b0, 1'b1, '0);
        step("fair_idle");
        for (int i = 0; i < NR; i++)
            check_val("fair.count", DW'(issue_count[i]), DW'(i == 0 ? 108 : 100));

        // Pointer wrap: move pointer to 2, then only requesters 3 and 1 ask.
        @(negedge clk);
        drive(4'b0010, 1'b0, 1'b1, '0);
        step("wrap_pre");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(4'b1010, 1'b0, 1'b1, '0);
            step("wrap");
            check_val("wrap.order", DW'(grant_id), DW'(exp_order[c]));
        end

        // Backpressure: chan_full high for 10 cycles with all requesters valid.
        we_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive('1, 1'b1, 1'b1, '0);
            step("bp");
        end
        check_val("bp.we_after_rise", DW'(we_seen <= 1), DW'(1));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive('1, 1'b0, 1'b1, '0);
            step("bp_release");
        end

        // Fence from requester 2 with the pointer parked at 2.
        @(negedge clk);
        drive(4'b0010, 1'b0, 1'b1, '0);
        step("fence_pre");
        @(negedge clk);
        drive('1, 1'b0, 1'b0, 4'b0100);
        step("fence_issue");
        check_val("fence.issue_gid", DW'(grant_id), DW'(2));
        we_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive('1, 1'b0, 1'b0, 4'b0100);
            step("fence_wait");
            check_val("fence.active", DW'(fence_active), DW'(1));
        end
        @(negedge clk);
        drive('1, 1'b0, 1'b1, '0);
        step("fence_release");
        check_val("fence.blocked_we", DW'(we_seen), DW'(0));
        @(negedge clk);
        drive('1, 1'b0, 1'b1, '0);
        step("fence_next");
        check_val("fence.next_gid", DW'(grant_id), DW'(3));
        check_val("fence.next_we", DW'(bus.chan_write_en), DW'(1));

        // Reset while draining after a fence.
        @(negedge clk);
        drive(4'b0001, 1'b0, 1'b0, 4'b0001);
        step("rstf_issue");
        for (int c = 0; c < SC + 2; c++) begin
            @(negedge clk);
            drive('1, 1'b0, 1'b0, '0);
            step("rstf_drain");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstf");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive('1, 1'b0, 1'b1, '0);
        step("rstf_after");
        check_val("rstf.first_gid", DW'(grant_id), DW'(0));

        // Random traffic with occasional fences, backpressure and drain delays.
        for (int c = 0; c < 1500; c++) begin
            logic [NR-1:0] fen;
            for (int i = 0; i < NR; i++) fen[i] = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            drive(NR'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), fen);
            step("rand");
        end
        @(negedge clk);
        drive('0, 1'b0, 1'b1, '0);
        step("rand_idle");
        for (int i = 0; i < NR; i++)
            check_val("rand.count", DW'(issue_count[i]), DW'(m_cnt[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx1_write_arbiter.md
# tx1_write_arbiter

Round-robin arbiter that shares one in-order write channel (TX1 path, write-fence aware) among `NUM_REQ` independent write requesters. It sits directly upstream of the write channel. It serialises requests into a single registered write stream and honours the channel's almost-full backpressure. It turns any requester's write fence into a global ordering point: after a fence is issued, nothing further is issued until the channel has drained.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..16.
- `HDR_WIDTH`, 61 — transaction header width.
- `DATA_WIDTH`, 512 — payload width.
- `SETTLE_CYCLES`, 3 — cycles to wait after a fence is issued before `chan_empty` is trusted, 1..15.
- `clk` in 1 — single clock, all logic on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `req_valid` in [NUM_REQ] — per-requester request valid.
- `req_meta` in [NUM_REQ][HDR_WIDTH] — per-requester header. Type field is `TX_META_TYPERANGE`.
- `req_data` in [NUM_REQ][DATA_WIDTH] — per-requester payload.
- `req_ready` out [NUM_REQ] — one-hot grant. A transfer occurs when `req_valid[i] && req_ready[i]`.
- `chan_meta` out HDR_WIDTH — header to the channel.
- `chan_data` out DATA_WIDTH — payload to the channel.
- `chan_write_en` out 1 — channel write strobe.
- `chan_full` in 1 — channel almost-full. Has at least 2 entries of slack.
- `chan_empty` in 1 — channel output FIFO empty.
- `grant_id` out $clog2(NUM_REQ) — index of the last accepted requester.
- `fence_active` out 1 — high whenever the arbiter is in either fence state.
- `issue_count` out [NUM_REQ][32] — per-requester count of accepted transactions. Wraps modulo 2^32.

## Operation
- **FSM states:** ARB, FENCE_SETTLE, FENCE_DRAIN. Reset state is ARB.
- **ARB state**
  - If `chan_full == 0`, pick the first `i` with `req_valid[i]` set, searching from `rr_ptr` upward modulo `NUM_REQ`.
  - Drive `req_ready = 1 << i`, combinationally from `req_valid`, `rr_ptr`, state and `chan_full`.
  - `req_ready` is all-zero when no request is valid, when `chan_full` is high, or outside ARB.
  - On a transfer:
    - Register `req_meta[i]` and `req_data[i]` to `chan_meta` and `chan_data`.
    - Register `chan_write_en = 1`.
    - Set `rr_ptr <= (i+1) % NUM_REQ` and `grant_id <= i`.
    - Increment `issue_count[i]` by 1.
- **Fence issue:** if the transferred header type equals `ASE_TX1_WRFENCE`, the fence itself is issued normally. The next state is FENCE_SETTLE and the settle counter loads `SETTLE_CYCLES`.
- **FENCE_SETTLE:** `req_ready` is all-zero. The counter decrements each cycle; when it reaches 0, go to FENCE_DRAIN.
- **FENCE_DRAIN:** `req_ready` is all-zero. When `chan_empty == 1` is sampled, go to ARB.
- **rr_ptr updates:** `rr_ptr` changes only on an accepted transfer. It does not change on idle cycles or during a fence.
- **Payload when idle:** `chan_meta` and `chan_data` hold their last value when `chan_write_en == 0`.
- **Simultaneous events**
  - `chan_full` rising in the same cycle as a valid request: no grant that cycle.
  - Fence and normal requests pending together: the round-robin order decides. A fence gets no priority.
- **Reset values:** `req_ready = 0`, `chan_write_en = 0`, `chan_meta = 0`, `chan_data = 0`, `grant_id = 0`, `fence_active = 0`, `issue_count = 0`, `rr_ptr = 0`, settle counter = 0.
- **Reset during a fence:** an asynchronous reset while in FENCE_SETTLE or FENCE_DRAIN returns to ARB with all state cleared. Any transaction already registered toward the channel is dropped from the strobe.

## Timing
- **Transfer latency:** a handshake at edge t puts `chan_write_en` high for exactly the cycle after t, with the matching header and data. Latency is 1 cycle.
- **Throughput:** at most 1 transaction per cycle, sustained while `chan_full == 0`.
- **Backpressure:** `chan_full` is sampled combinationally in the grant cycle. One transaction can be in flight after `chan_full` rises; the channel's slack absorbs it.
- **Fence blocking:** after a fence handshake at edge t, the earliest next grant is at edge t + SETTLE_CYCLES + 2. That is the first edge on which a high `chan_empty` is sampled in FENCE_DRAIN, plus 1 cycle.
- **fence_active:** registered from the FSM state. High from t+1 until the cycle after the transition back to ARB.

## Structure
- **Shared package (`tx1_arb_pkg`):** the state enum (ARB, FENCE_SETTLE, FENCE_DRAIN) and the `rr_pick` function (rotating first-one search, returns the index and a found flag).
- **Channel type codes:** the type-field range and type codes come from the existing global header macros. They are not redefined.
- **Sub-module:** one natural sub-module, `rr_priority_picker`. It is purely combinational: request vector plus pointer in, one-hot grant and index out.

## Test plan
- **Single requester:** requester 0 sends 8 back-to-back writes with `chan_full = 0` -> `chan_write_en` high for 8 consecutive cycles starting 1 cycle later; `issue_count[0] == 8`.
- **Round-robin fairness:** all 4 requesters continuously valid -> grants in order 0,1,2,3,0,1,…; after 400 cycles each `issue_count == 100`.
- **Pointer wrap-around:** only requesters 3 and 1 valid, `rr_ptr` at 2 -> grant order 3,1,3,1; `rr_ptr` wraps from 3 to 0.
- **Backpressure:** `chan_full` asserted for 10 cycles with all requesters valid -> `req_ready` all-zero for those 10 cycles; at most 1 `chan_write_en` after the rise; no transaction lost or duplicated, checked by per-requester sequence tags.
- **Fence blocking:** requester 2 sends a fence, others valid, `chan_empty` held low for 20 cycles -> no grant until 1 cycle after `chan_empty` rises; `fence_active` high throughout; the grant after the fence goes to requester 3.
- **Reset mid-fence:** `rst_n` pulsed low while in FENCE_DRAIN -> all outputs 0 immediately; arbiter grants requester 0 on the first valid request after release.
